// File: rtl/la_dffpipe_stage.sv
// One register slice of la_dffpipe: a valid flop plus a DW-bit data word.
// The data word loads only when a valid word moves in, so idle cycles
// leave the data flops untouched.
module la_dffpipe_stage #(
  parameter int DW        = 1,
  parameter int RESETDATA = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          adv,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_d;
  logic          valid_q;
  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;
  logic          load;

  // Next-state: clear empties the slice, otherwise take the upstream word on advance.
  always_comb begin
    load    = adv & src_valid & ~clear;
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = src_valid;
    end
    if (load) begin
      data_d = src_data;
    end
  end

  // Valid flop always takes the asynchronous reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  if (RESETDATA != 0) begin : g_data_rst
    // Data flops cleared by reset when requested.
    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end
  end else begin : g_data_norst
    // Data flops without reset; contents are don't-care until first load.
    always_ff @(posedge clk) begin
      data_q <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/la_dffpipe.sv
// DEPTH-stage bubble-collapsing pipeline register with valid/ready handshake,
// synchronous flush and an occupancy count. Outputs come straight from the
// last stage's flops; only in_ready is combinational (from out_ready).
module la_dffpipe #(
  parameter int    DW        = 1,
  parameter int    DEPTH     = 2,
  parameter int    RESETDATA = 0,
  parameter string PROP      = "DEFAULT"
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DW-1:0]    d     [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [DW-1:0]    src_d [DEPTH];
  logic             accept;
  logic             emit;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    count_q;

  // Stage i may advance when it, or any stage downstream of it, is empty,
  // or when the output is being drained. Written as an explicit scan so the
  // chain has no self-referencing vector.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v[j]) adv[i] = 1'b1;
      end
    end
  end

  assign in_ready = adv[0] & ~clear;
  assign accept   = in_valid & in_ready;
  assign emit     = v[DEPTH-1] & out_ready;

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    src_v    = '0;
    src_v[0] = accept;
    src_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    la_dffpipe_stage #(
      .DW        (DW),
      .RESETDATA (RESETDATA)
    ) u_stage (
      .clk       (clk),
      .nreset    (nreset),
      .clear     (clear),
      .adv       (adv[i]),
      .src_valid (src_v[i]),
      .src_data  (src_d[i]),
      .valid     (v[i]),
      .data      (d[i])
    );
  end

  // Technology-mapping hook: a non-default PROP would select alternate cells here.
  if (PROP != "DEFAULT") begin : g_prop_hook
  end

  // Occupancy tracks accepts and emits; flush zeroes it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign count     = count_q;

endmodule
